// File: rtl/conv_window_gen.sv
// Streaming sliding-window generator: buffers FILTERHEIGHT-1 lines and emits every
// FILTERHEIGHT x FILTERWIDTH window of a raster-order image as one flat bus.
module conv_window_gen #(
  parameter int BITWIDTH     = 8,
  parameter int DATACHANNEL  = 3,
  parameter int FILTERHEIGHT = 5,
  parameter int FILTERWIDTH  = 5,
  parameter int IMGWIDTH     = 32,
  parameter int IMGHEIGHT    = 32
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic [BITWIDTH*DATACHANNEL-1:0]                         in_data,
  input  logic                                                    in_valid,
  output logic                                                    in_ready,
  output logic [BITWIDTH*DATACHANNEL*FILTERHEIGHT*FILTERWIDTH-1:0] out_data,
  output logic                                                    out_valid,
  input  logic                                                    out_ready,
  output logic                                                    out_last
);
  localparam int PW = BITWIDTH * DATACHANNEL;
  localparam int NL = FILTERHEIGHT - 1;
  localparam int WW = PW * FILTERHEIGHT * FILTERWIDTH;
  localparam int CW = (IMGWIDTH > 1) ? $clog2(IMGWIDTH) : 1;
  localparam int RW = (IMGHEIGHT > 1) ? $clog2(IMGHEIGHT) : 1;

  // r_lb[0] holds the previous row, r_lb[NL-1] the oldest buffered row
  logic [PW-1:0] r_lb [NL][IMGWIDTH];
  logic [WW-1:0] r_win;
  logic [WW-1:0] w_win_nxt;
  logic [WW-1:0] r_out_data;
  logic          r_out_valid;
  logic          r_out_last;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_acc;
  logic          w_emit;
  logic          w_col_end;
  logic          w_row_end;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_acc     = in_valid && in_ready;
  assign w_col_end = (r_col == CW'(IMGWIDTH - 1));
  assign w_row_end = (r_row == RW'(IMGHEIGHT - 1));
  // row gating keeps stale lines from a previous image out of every emitted window
  assign w_emit    = w_acc && (r_row >= RW'(FILTERHEIGHT - 1)) && (r_col >= CW'(FILTERWIDTH - 1));

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

  always_comb begin
    w_win_nxt = r_win;
    for (int r = 0; r < FILTERHEIGHT; r++) begin
      for (int c = 0; c < FILTERWIDTH - 1; c++)
        w_win_nxt[(r*FILTERWIDTH+c)*PW +: PW] = r_win[(r*FILTERWIDTH+c+1)*PW +: PW];
    end
    for (int r = 0; r < NL; r++)
      w_win_nxt[(r*FILTERWIDTH+FILTERWIDTH-1)*PW +: PW] = r_lb[NL-1-r][r_col];
    w_win_nxt[(NL*FILTERWIDTH+FILTERWIDTH-1)*PW +: PW] = in_data;
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb[0][r_col] <= in_data;
      for (int k = 1; k < NL; k++)
        r_lb[k][r_col] <= r_lb[k-1][r_col];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_win <= w_win_nxt;
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_win_nxt;
        r_out_last  <= w_row_end && w_col_end;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: 3x3 windows over a 5x5, 3-channel image; directed
// window tables plus randomized traffic against an image-array reference model.
module tb_conv_window_gen;
  localparam int PW = 24;
  localparam int WW = 9 * PW;

  logic          clk = 0;
  logic          rst = 1;
  logic [PW-1:0] in_data = '0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1;
  logic          out_last;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { int tl; bit last; } vec_t;
  vec_t tbl[9];

  logic [WW:0]   got_q[$];
  logic [WW:0]   exp_q[$];
  logic [PW-1:0] img[5][5];
  int            m_row = 0;
  int            m_col = 0;

  conv_window_gen #(
    .BITWIDTH(8), .DATACHANNEL(3), .FILTERHEIGHT(3), .FILTERWIDTH(3),
    .IMGWIDTH(5), .IMGHEIGHT(5)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mkpix(int v);
    return {8'(v + 100), 8'(v + 50), 8'(v)};
  endfunction

  // window whose top-left pixel has value tl in a row-major image of width 5
  function automatic logic [WW-1:0] tl_win(int tl);
    logic [WW-1:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*PW +: PW] = mkpix(tl + r*5 + c);
    return w;
  endfunction

  function automatic logic [WW-1:0] img_win(int row, int col, logic [PW-1:0] newpix);
    logic [WW-1:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*PW +: PW] = (r == 2 && c == 2) ? newpix : img[row-2+r][col-2+c];
    return w;
  endfunction

  // reference model and output monitor; handshakes are sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      m_row <= 0;
      m_col <= 0;
      got_q.delete();
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (in_valid && in_ready) begin
        img[m_row][m_col] <= in_data;
        if (m_row >= 2 && m_col >= 2)
          exp_q.push_back({(m_row == 4 && m_col == 4), img_win(m_row, m_col, in_data)});
        m_col <= (m_col == 4) ? 0 : m_col + 1;
        if (m_col == 4) m_row <= (m_row == 4) ? 0 : m_row + 1;
      end
    end
  end

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic cmp_tbl(string nm, int base, int off);
    for (int k = 0; k < 9; k++)
      chk(nm, (off + k < got_q.size()) ? got_q[off + k] : 'x,
          {tbl[k].last, tl_win(base + tbl[k].tl)});
  endtask

  // pixel k of the stream is image k/25, position k%25; value = 100*image + base + pos
  task automatic stream(int base, int npix, int gap_pct, bit rnd_data, bit rnd_ordy, int hold_at);
    bit            acc;
    bit            ordy;
    int            pk;
    logic [WW-1:0] snap;
    for (int k = 0; k < npix; k++) begin
      pk = k % 25;
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 0;
        if (rnd_ordy) out_ready = 1'($urandom_range(1));
        @(posedge clk); #1;
      end
      in_data  = rnd_data ? PW'($urandom) : mkpix((k / 25) * 100 + base + pk);
      in_valid = 1;
      acc = 0;
      ordy = 0;
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk);
        acc  = in_ready;
        ordy = out_ready;
        @(posedge clk); #1;
        if (!acc && rnd_ordy) out_ready = 1'($urandom_range(1));
      end
      if (!acc) begin
        n_vec++; n_err++;
        $display("FAIL accept_timeout: pixel %0d not accepted within 50 cycles", k);
      end
      if (ordy) chk("ovalid_after_accept", out_valid, (pk / 5 >= 2 && pk % 5 >= 2));
      if (k == hold_at) begin
        out_ready = 0;
        snap = out_data;
        for (int h = 0; h < 4; h++) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_out_valid", out_valid, 1);
          chk("bp_data_stable", out_data, snap);
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
      if (rnd_ordy) out_ready = 1'($urandom_range(1));
    end
    in_valid = 0;
  endtask

  initial begin
    tbl[0] = '{0, 0};  tbl[1] = '{1, 0};  tbl[2] = '{2, 0};
    tbl[3] = '{5, 0};  tbl[4] = '{6, 0};  tbl[5] = '{7, 0};
    tbl[6] = '{10, 0}; tbl[7] = '{11, 0}; tbl[8] = '{12, 1};

    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    do_reset();
    chk("reset_out_last", out_last, 0);
    chk("reset_out_data", out_data, 0);

    // continuous streaming
    stream(0, 25, 0, 0, 0, -1);
    drain();
    chk("stream_count", got_q.size(), 9);
    cmp_tbl("stream_win", 0, 0);

    // backpressure after the first window
    do_reset();
    stream(0, 25, 0, 0, 0, 12);
    drain();
    chk("bp_count", got_q.size(), 9);
    cmp_tbl("bp_win", 0, 0);

    // input bubbles
    do_reset();
    stream(0, 25, 50, 0, 0, -1);
    drain();
    chk("bubble_count", got_q.size(), 9);
    cmp_tbl("bubble_win", 0, 0);

    // back-to-back images, second one offset by 100
    do_reset();
    stream(0, 50, 0, 0, 0, -1);
    drain();
    chk("b2b_count", got_q.size(), 18);
    cmp_tbl("b2b_img1", 0, 0);
    cmp_tbl("b2b_img2", 100, 9);

    // asynchronous reset after pixel 17, then a fresh image
    do_reset();
    stream(0, 18, 0, 0, 0, -1);
    chk("pre_rst_out_valid", out_valid, 1);
    #2 rst = 1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 0;
    stream(0, 25, 0, 0, 0, -1);
    drain();
    chk("post_rst_count", got_q.size(), 9);
    cmp_tbl("post_rst_win", 0, 0);

    // random data, bubbles and output stalls over three images
    do_reset();
    stream(0, 75, 30, 1, 1, -1);
    drain();
    chk("rnd_model_count", exp_q.size(), 27);
    chk("rnd_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      chk("rnd_win", (k < got_q.size()) ? got_q[k] : 'x, exp_q[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
